// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// Optional feature macro: MDU_MADD_EN (enables MADD/MADDU accumulate ops).
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8
    } md_op_e;

    typedef enum logic {
        MDS_IDLE = 1'b0,
        MDS_BUSY = 1'b1
    } mds_e;

    // Ops that occupy the unit for a multi-cycle sequence.
    function automatic logic is_start_op(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU:                  r = 1'b1;
`endif
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E/D-stage interface of the multiply/divide sequencer.
interface mdu_ctrl_if;
    logic [3:0]  E_MDOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_MDUse;
    logic        Start;
    logic        Busy;
    logic        MD_Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output E_MDOp, E_A, E_B, D_MDUse,
        input  Start, Busy, MD_Stall, HI, LO
    );

    modport slave (
        input  E_MDOp, E_A, E_B, D_MDUse,
        output Start, Busy, MD_Stall, HI, LO
    );
endinterface

// File: rtl/mdu_ctrl_calc.sv
// mdu_calc: combinational 64-bit HI/LO result for a multiply/divide op.
// Macro MDU_MADD_EN adds the accumulate forms. Divide by zero returns
// the current HI/LO so the eventual commit leaves them unchanged.
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);
    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic        [63:0] res;

    // Products are computed full width; the op selects which one is used.
    always_comb begin
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'b0, a} * {32'b0, b};
        res   = {hi, lo};
        case (op)
            MD_MULT:  res = sprod;
            MD_MULTU: res = uprod;
            MD_DIV:   if (b != 32'd0)
                          res = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
            MD_DIVU:  if (b != 32'd0)
                          res = {a % b, a / b};
`ifdef MDU_MADD_EN
            MD_MADD:  res = {hi, lo} + sprod;
            MD_MADDU: res = {hi, lo} + uprod;
`endif
            default:  res = {hi, lo};
        endcase
    end

    assign res_hi = res[63:32];
    assign res_lo = res[31:0];
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer. Result is computed at issue,
// held for a fixed latency, then committed to HI/LO.
// Macro MDU_MADD_EN enables MADD/MADDU (ops 7/8); otherwise they decode as NONE.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    mdu_ctrl_if.slave    md
);
    mds_e        state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [31:0] res_hi, res_lo;
    logic        start;

    mdu_calc u_calc (
        .op     (md.E_MDOp),
        .a      (md.E_A),
        .b      (md.E_B),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign start       = is_start_op(md.E_MDOp) && (state_q == MDS_IDLE);
    assign md.Start    = start;
    assign md.Busy     = busy_q;
    // Stall covers the issue cycle too, so a following mfhi/mflo waits it out.
    assign md.MD_Stall = md.D_MDUse & (start | busy_q);
    assign md.HI       = hi_q;
    assign md.LO       = lo_q;

    // Next-state: issue from IDLE, count down in BUSY, commit on the last cycle.
    // Ops seen while BUSY are ignored.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            MDS_IDLE: begin
                if (start) begin
                    cnt_d     = is_div_op(md.E_MDOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    state_d   = MDS_BUSY;
                    busy_d    = 1'b1;
                end else if (md.E_MDOp == MD_MTHI) begin
                    hi_d = md.E_A;
                end else if (md.E_MDOp == MD_MTLO) begin
                    lo_d = md.E_A;
                end
            end
            MDS_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = MDS_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = MDS_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any pending result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= MDS_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl. Expected HI/LO pairs are queued
// at issue and compared when Busy drops.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    logic [63:0] sb_q[$];

    mdu_ctrl_if md();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md.E_MDOp = op;
        md.E_A    = a;
        md.E_B    = b;
    endtask

    // Issue a multi-cycle op, count Busy and MD_Stall cycles, then score HI/LO.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int exp_busy, input int exp_stall);
        int nb;
        int ns;
        logic [63:0] want;
        sb_q.push_back(exp);
        @(negedge clk);
        drive(op, a, b);
        #1;
        chk({tag, ".start"}, 64'(md.Start), 64'd1);
        ns = md.MD_Stall ? 1 : 0;
        @(posedge clk);
        #1;
        drive(MD_NONE, 32'd0, 32'd0);
        nb = 0;
        while (md.Busy && nb < 40) begin
            nb++;
            if (md.MD_Stall) ns++;
            @(posedge clk);
            #1;
        end
        chk({tag, ".busy_cycles"}, 64'(nb), 64'(exp_busy));
        chk({tag, ".stall_cycles"}, 64'(ns), 64'(exp_stall));
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            want = sb_q.pop_front();
            chk({tag, ".hilo"}, {md.HI, md.LO}, want);
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        drive(op, a, 32'd0);
        @(posedge clk);
        #1;
        drive(MD_NONE, 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] ex;
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b0;
        md.D_MDUse = 1'b0;
        drive(MD_NONE, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 64'(md.Busy), 64'd0);
        chk("rst.hilo", {md.HI, md.LO}, 64'd0);
        chk("rst.stall", 64'(md.MD_Stall), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Signed and unsigned multiply of the same operands.
        run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 5, 0);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 5, 0);

        // Signed divide with a dependent instruction waiting in D.
        md.D_MDUse = 1'b1;
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 11);
        md.D_MDUse = 1'b0;
        run_op("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 10, 0);

        // MTHI in IDLE writes next edge with no busy.
        mt(MD_MTHI, 32'h0000_1234);
        chk("mthi.hi", 64'(md.HI), 64'h1234);
        chk("mthi.busy", 64'(md.Busy), 64'd0);

        // MTLO while busy is dropped; LO keeps its value until commit.
        mt(MD_MTLO, 32'h0000_00AA);
        sb_q.push_back(64'd12);
        @(negedge clk);
        drive(MD_MULT, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        drive(MD_NONE, 32'd0, 32'd0);
        mt(MD_MTLO, 32'h0000_DEAD);
        chk("mtlo_busy.lo", 64'(md.LO), 64'hAA);
        chk("mtlo_busy.busy", 64'(md.Busy), 64'd1);
        for (int i = 0; i < 20 && md.Busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("mtlo_busy.done", 64'(md.Busy), 64'd0);
        chk("mtlo_busy.hilo", {md.HI, md.LO}, sb_q.pop_front());

        // Divide by zero keeps HI/LO.
        mt(MD_MTHI, 32'd5);
        mt(MD_MTLO, 32'd6);
        run_op("divu0", MD_DIVU, 32'd100, 32'd0, {32'd5, 32'd6}, 10, 0);

`ifdef MDU_MADD_EN
        run_op("madd", MD_MADD, 32'hFFFF_FFFF, 32'd1, {32'd5, 32'd5}, 5, 0);
        run_op("maddu", MD_MADDU, 32'hFFFF_FFFF, 32'd1, {32'd6, 32'd4}, 5, 0);
`else
        @(negedge clk);
        drive(MD_MADD, 32'd9, 32'd9);
        #1;
        chk("madd_off.start", 64'(md.Start), 64'd0);
        @(posedge clk);
        #1;
        drive(MD_NONE, 32'd0, 32'd0);
        chk("madd_off.busy", 64'(md.Busy), 64'd0);
        chk("madd_off.hilo", {md.HI, md.LO}, {32'd5, 32'd6});
`endif

        // A few random unsigned ops against a 64-bit reference.
        for (int k = 0; k < 4; k++) begin
            ra = $urandom;
            rb = $urandom_range(1, 32'h7FFF_FFFF);
            ex = {32'b0, ra} * {32'b0, rb};
            run_op("rnd_multu", MD_MULTU, ra, rb, ex, 5, 0);
            rb = $urandom_range(1, 1000);
            ex = {ra % rb, ra / rb};
            run_op("rnd_divu", MD_DIVU, ra, rb, ex, 10, 0);
        end

        // Asynchronous reset mid-divide.
        @(negedge clk);
        drive(MD_DIV, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        drive(MD_NONE, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("areset.busy", 64'(md.Busy), 64'd0);
        chk("areset.hilo", {md.HI, md.LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("areset.discard", {md.HI, md.LO}, 64'd0);
        run_op("post_rst", MD_MULTU, 32'd6, 32'd7, 64'd42, 5, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
